// File: rtl/riscv_trace_pkg.sv
// ----------------------------------------------------------------------------
// riscv_trace_pkg
//   Shared types and helpers for the retire-trace buffer:
//   - capture state encoding (IDLE/ARMED/CAPTURE/DONE)
//   - default field widths and the trace entry layout
//   - entry width helper plus pack/unpack functions for the default layout
// ----------------------------------------------------------------------------
package riscv_trace_pkg;

   localparam int XLEN_DEF = 32;
   localparam int TS_W_DEF = 16;
   localparam int INSTR_W  = 32;
   localparam int REG_W    = 5;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } trace_state_e;

   // Entry layout, most significant field first: {ts, pc, instr, rd, rd_data}
   typedef struct packed {
      logic [TS_W_DEF-1:0] ts;
      logic [XLEN_DEF-1:0] pc;
      logic [INSTR_W-1:0]  instr;
      logic [REG_W-1:0]    rd;
      logic [XLEN_DEF-1:0] rd_data;
   } trace_entry_t;

   localparam int ENTRY_W_DEF = $bits(trace_entry_t);

   function automatic int entry_width(input int xlen, input int ts_w);
      return ts_w + 2 * xlen + INSTR_W + REG_W;
   endfunction

   function automatic trace_entry_t pack_entry(
      input logic [TS_W_DEF-1:0] ts,
      input logic [XLEN_DEF-1:0] pc,
      input logic [INSTR_W-1:0]  instr,
      input logic [REG_W-1:0]    rd,
      input logic [XLEN_DEF-1:0] rd_data
   );
      trace_entry_t e;
      e.ts      = ts;
      e.pc      = pc;
      e.instr   = instr;
      e.rd      = rd;
      e.rd_data = rd_data;
      return e;
   endfunction

   function automatic trace_entry_t unpack_entry(input logic [ENTRY_W_DEF-1:0] raw);
      return trace_entry_t'(raw);
   endfunction

endpackage

// File: rtl/trace_buf_mem.sv
// ----------------------------------------------------------------------------
// trace_buf_mem
//   DEPTH x W register array holding trace entries. One synchronous write
//   port, one asynchronous read port. Contents are not reset; validity is
//   tracked by the owner's count.
// Ports:
//   clk      in  clock
//   wr_en    in  write strobe
//   wr_addr  in  write index
//   wr_data  in  entry to store
//   rd_addr  in  read index
//   rd_data  out entry at rd_addr (combinational)
// ----------------------------------------------------------------------------
module trace_buf_mem #(
   parameter  int DEPTH = 16,
   parameter  int W     = 117,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);

   logic [W-1:0] mem [DEPTH];

   // Storage write port
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/riscv_retire_trace_buffer.sv
// ----------------------------------------------------------------------------
// riscv_retire_trace_buffer
//   Captures one entry per retired instruction of the single-cycle RISC-V
//   core into a DEPTH-deep buffer, then lets a consumer drain it.
//   Capture starts on a PC trigger (or the first retire), ends when full
//   (stop mode), on stop, or when a self-loop (halt) is detected.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   arm                      clear buffer and flags, enter ARMED
//   stop                     end capture (ARMED/CAPTURE -> DONE)
//   trig_en, trig_pc         PC trigger enable and address
//   ret_valid .. ret_rd_data retire stream from the core
//   rd_ready                 consumer accepts rd_entry
//   rd_valid, rd_entry       oldest unread entry {ts, pc, instr, rd, rd_data}
//   state                    IDLE=0 ARMED=1 CAPTURE=2 DONE=3
//   count                    valid entries held
//   overflow                 sticky: circular mode dropped an entry
//   halted                   sticky: self-loop detected
// ----------------------------------------------------------------------------
module riscv_retire_trace_buffer
   import riscv_trace_pkg::*;
#(
   parameter  int XLEN        = 32,
   parameter  int DEPTH       = 16,
   parameter  int TS_W        = 16,
   parameter  int WRAP_MODE   = 0,
   parameter  int HALT_REPEAT = 4,
   localparam int ENTRY_W     = entry_width(XLEN, TS_W),
   localparam int AW          = $clog2(DEPTH),
   localparam int CW          = AW + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               arm,
   input  logic               stop,
   input  logic               trig_en,
   input  logic [XLEN-1:0]    trig_pc,
   input  logic               ret_valid,
   input  logic [XLEN-1:0]    ret_pc,
   input  logic [31:0]        ret_instr,
   input  logic               ret_rd_we,
   input  logic [4:0]         ret_rd,
   input  logic [XLEN-1:0]    ret_rd_data,
   input  logic               rd_ready,
   output logic               rd_valid,
   output logic [ENTRY_W-1:0] rd_entry,
   output logic [1:0]         state,
   output logic [CW-1:0]      count,
   output logic               overflow,
   output logic               halted
);

   localparam int RW = $clog2(HALT_REPEAT + 1);

   trace_state_e        fsm;
   logic [TS_W-1:0]     ts;
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [XLEN-1:0]     prev_pc;
   logic                prev_valid;
   logic [RW-1:0]       rpt;
   logic [RW-1:0]       rpt_next;
   logic                tracking;
   logic                trig_hit;
   logic                halt_hit;
   logic                full;
   logic                wr_en;
   logic                pop;
   logic [ENTRY_W-1:0]  wr_data;

   assign tracking = (fsm == ST_ARMED) || (fsm == ST_CAPTURE);
   assign trig_hit = ret_valid && (!trig_en || (ret_pc == trig_pc));
   assign full     = (count == CW'(DEPTH));

   // Repeat count the halt detector would hold after this cycle's retire
   always_comb begin
      rpt_next = rpt;
      if (ret_valid) begin
         if (prev_valid && (ret_pc == prev_pc)) begin
            if (rpt == RW'(HALT_REPEAT)) begin
               rpt_next = rpt;
            end else begin
               rpt_next = rpt + RW'(1);
            end
         end else begin
            rpt_next = RW'(1);
         end
      end else begin
         rpt_next = rpt;
      end
   end

   // Only the first arrival at HALT_REPEAT counts as the halt event
   assign halt_hit = tracking && ret_valid && !halted && (rpt_next == RW'(HALT_REPEAT));

   // In stop mode the buffer never accepts a write once it holds DEPTH entries
   assign wr_en = !arm &&
                  (((fsm == ST_ARMED) && trig_hit && !stop) ||
                   ((fsm == ST_CAPTURE) && ret_valid)) &&
                  ((WRAP_MODE != 0) || !full);

   assign rd_valid = ((fsm == ST_DONE) || (fsm == ST_IDLE)) && (count != {CW{1'b0}});
   assign pop      = rd_valid && rd_ready;
   assign state    = fsm;

   assign wr_data = {ts, ret_pc, ret_instr, (ret_rd_we ? ret_rd : 5'd0), ret_rd_data};

   trace_buf_mem #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (wr_data),
      .rd_addr (rd_ptr),
      .rd_data (rd_entry)
   );

   // Free-running timestamp, unaffected by arm
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ts <= {TS_W{1'b0}};
      end else begin
         ts <= ts + TS_W'(1);
      end
   end

   // Capture FSM, pointers, count, sticky flags and halt detector
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm        <= ST_IDLE;
         wr_ptr     <= {AW{1'b0}};
         rd_ptr     <= {AW{1'b0}};
         count      <= {CW{1'b0}};
         overflow   <= 1'b0;
         halted     <= 1'b0;
         prev_pc    <= {XLEN{1'b0}};
         prev_valid <= 1'b0;
         rpt        <= {RW{1'b0}};
      end else if (arm) begin
         fsm        <= ST_ARMED;
         wr_ptr     <= {AW{1'b0}};
         rd_ptr     <= {AW{1'b0}};
         count      <= {CW{1'b0}};
         overflow   <= 1'b0;
         halted     <= 1'b0;
         prev_valid <= 1'b0;
         rpt        <= {RW{1'b0}};
      end else begin
         if (tracking && ret_valid) begin
            prev_pc    <= ret_pc;
            prev_valid <= 1'b1;
            rpt        <= rpt_next;
         end
         if (halt_hit) begin
            halted <= 1'b1;
         end

         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (full) begin
               // Circular mode: oldest entry is overwritten
               rd_ptr   <= rd_ptr + AW'(1);
               overflow <= 1'b1;
            end else begin
               count <= count + CW'(1);
            end
         end

         case (fsm)
            ST_IDLE: begin
               if (pop) begin
                  rd_ptr <= rd_ptr + AW'(1);
                  count  <= count - CW'(1);
               end
            end
            ST_ARMED: begin
               if (stop || halt_hit) begin
                  fsm <= ST_DONE;
               end else if (trig_hit) begin
                  fsm <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (stop || halt_hit) begin
                  fsm <= ST_DONE;
               end else if ((WRAP_MODE == 0) && wr_en && (count == CW'(DEPTH - 1))) begin
                  fsm <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (count == {CW{1'b0}}) begin
                  fsm <= ST_IDLE;
               end else if (pop) begin
                  rd_ptr <= rd_ptr + AW'(1);
                  count  <= count - CW'(1);
                  if (count == CW'(1)) begin
                     fsm <= ST_IDLE;
                  end
               end
            end
            default: begin
               fsm <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_retire_trace_buffer.sv
// ----------------------------------------------------------------------------
// tb_riscv_retire_trace_buffer
//   Directed bench: one stop-mode instance (a_*) and one circular-mode
//   instance (b_*) share the same stimulus. Expected values are hand-derived.
// ----------------------------------------------------------------------------
module tb_riscv_retire_trace_buffer;
   import riscv_trace_pkg::*;

   localparam int XLEN    = 32;
   localparam int DEPTH   = 16;
   localparam int TS_W    = 16;
   localparam int ENTRY_W = entry_width(XLEN, TS_W);
   localparam int CW      = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            arm = 1'b0;
   logic            stop = 1'b0;
   logic            trig_en = 1'b0;
   logic [XLEN-1:0] trig_pc = '0;
   logic            ret_valid = 1'b0;
   logic [XLEN-1:0] ret_pc = '0;
   logic [31:0]     ret_instr = '0;
   logic            ret_rd_we = 1'b0;
   logic [4:0]      ret_rd = '0;
   logic [XLEN-1:0] ret_rd_data = '0;
   logic            rd_ready = 1'b0;

   logic               a_rd_valid, b_rd_valid;
   logic [ENTRY_W-1:0] a_entry, b_entry;
   logic [1:0]         a_state, b_state;
   logic [CW-1:0]      a_count, b_count;
   logic               a_overflow, b_overflow;
   logic               a_halted, b_halted;

   int errors = 0;
   int checks = 0;
   logic [TS_W-1:0] tb_ts;
   logic [TS_W-1:0] trig_ts;
   trace_entry_t    e;

   riscv_retire_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .TS_W(TS_W), .WRAP_MODE(0), .HALT_REPEAT(4)) dut_a (
      .clk(clk), .rst(rst), .arm(arm), .stop(stop), .trig_en(trig_en), .trig_pc(trig_pc),
      .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr), .ret_rd_we(ret_rd_we),
      .ret_rd(ret_rd), .ret_rd_data(ret_rd_data), .rd_ready(rd_ready),
      .rd_valid(a_rd_valid), .rd_entry(a_entry), .state(a_state), .count(a_count),
      .overflow(a_overflow), .halted(a_halted));

   riscv_retire_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .TS_W(TS_W), .WRAP_MODE(1), .HALT_REPEAT(4)) dut_b (
      .clk(clk), .rst(rst), .arm(arm), .stop(stop), .trig_en(trig_en), .trig_pc(trig_pc),
      .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr), .ret_rd_we(ret_rd_we),
      .ret_rd(ret_rd), .ret_rd_data(ret_rd_data), .rd_ready(rd_ready),
      .rd_valid(b_rd_valid), .rd_entry(b_entry), .state(b_state), .count(b_count),
      .overflow(b_overflow), .halted(b_halted));

   always #5 clk = ~clk;

   // Reference cycle counter: timestamp expected to be captured this cycle
   always @(posedge clk or negedge rst) begin
      if (!rst) tb_ts <= '0;
      else      tb_ts <= tb_ts + 16'd1;
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic we,
                         input logic [4:0] rd, input logic [31:0] data);
      ret_valid   = 1'b1;
      ret_pc      = pc;
      ret_instr   = instr;
      ret_rd_we   = we;
      ret_rd      = rd;
      ret_rd_data = data;
      tick();
      ret_valid   = 1'b0;
   endtask

   initial begin
      // ---- reset values ----
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", a_state, 2'd0);
      check("rst_count", a_count, 5'd0);
      check("rst_rd_valid", a_rd_valid, 1'b0);
      check("rst_overflow", b_overflow, 1'b0);
      check("rst_halted", a_halted, 1'b0);
      rst = 1'b1;
      tick();

      // ---- 1: reset asserted mid-capture with 5 entries ----
      trig_en = 1'b0;
      do_arm();
      for (int i = 0; i < 5; i++) retire(32'(i * 4), 32'h0000_0013, 1'b0, 5'd0, 32'd0);
      check("t1_count5", a_count, 5'd5);
      check("t1_capture", a_state, 2'd2);
      #2 rst = 1'b0;
      #1;
      check("t1_async_state", a_state, 2'd0);
      check("t1_async_count", a_count, 5'd0);
      check("t1_async_rd_valid", a_rd_valid, 1'b0);
      check("t1_async_overflow", a_overflow, 1'b0);
      check("t1_async_halted", a_halted, 1'b0);
      #2 rst = 1'b1;
      tick();

      // ---- 2: PC trigger at 0x10, stop-mode fill; 5: toggled drain ----
      trig_en = 1'b1;
      trig_pc = 32'h10;
      do_arm();
      check("t2_armed", a_state, 2'd1);
      for (int i = 0; i < 20; i++) begin
         if (i == 4) trig_ts = tb_ts;
         retire(32'(i * 4), 32'h0000_0013, 1'b0, 5'd7, 32'(i));
      end
      check("t2_done", a_state, 2'd3);
      check("t2_count16", a_count, 5'd16);
      check("t2_no_overflow", a_overflow, 1'b0);
      check("t2_rd_valid", a_rd_valid, 1'b1);
      retire(32'h50, 32'h0000_0013, 1'b0, 5'd0, 32'd0);
      check("t2_full_ignores", a_count, 5'd16);
      check("t2_wrap_overflow", b_overflow, 1'b1);
      check("t2_wrap_count", b_count, 5'd16);
      check("t2_wrap_capture", b_state, 2'd2);
      for (int i = 0; i < 16; i++) begin
         e = unpack_entry(a_entry);
         check("t5_pc", e.pc, 32'(32'h10 + i * 4));
         check("t5_ts", e.ts, 16'(trig_ts + 16'(i)));
         if (i == 0) begin
            check("t2_rd_zero_no_we", e.rd, 5'd0);
            check("t2_rd_data", e.rd_data, 32'd4);
         end
         rd_ready = 1'b1;
         tick();
         rd_ready = 1'b0;
         check("t5_count_pop", a_count, 5'(15 - i));
         tick();
      end
      check("t5_idle", a_state, 2'd0);
      check("t5_rd_valid_low", a_rd_valid, 1'b0);

      // ---- 3: circular mode, 20 retires then stop ----
      trig_en = 1'b0;
      do_arm();
      for (int i = 0; i < 20; i++) retire(32'(i * 4), 32'h0000_0013, 1'b0, 5'd0, 32'd0);
      do_stop();
      check("t3_wrap_done", b_state, 2'd3);
      check("t3_wrap_count", b_count, 5'd16);
      check("t3_wrap_overflow", b_overflow, 1'b1);
      check("t3_stop_count", a_count, 5'd16);
      check("t3_stop_overflow", a_overflow, 1'b0);
      e = unpack_entry(a_entry);
      check("t3_stop_first_pc", e.pc, 32'h0);
      rd_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         e = unpack_entry(b_entry);
         check("t3_wrap_pc", e.pc, 32'(32'h10 + i * 4));
         tick();
      end
      rd_ready = 1'b0;
      check("t3_wrap_idle", b_state, 2'd0);
      check("t3_wrap_empty", b_count, 5'd0);

      // ---- 4: self-loop jal x0,0 at 0x24 ----
      do_arm();
      retire(32'h20, 32'h0000_0013, 1'b0, 5'd0, 32'd0);
      for (int k = 0; k < 6; k++) retire(32'h24, 32'h0000_006f, 1'b0, 5'd0, 32'd0);
      check("t4_halted", a_halted, 1'b1);
      check("t4_done", a_state, 2'd3);
      check("t4_count", a_count, 5'd5);
      check("t4_wrap_halted", b_halted, 1'b1);
      rd_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         e = unpack_entry(a_entry);
         check("t4_pc", e.pc, (i == 0) ? 32'h20 : 32'h24);
         tick();
      end
      rd_ready = 1'b0;
      check("t4_idle", a_state, 2'd0);
      check("t4_halted_sticky", a_halted, 1'b1);

      // ---- stop in ARMED: DONE empty, then IDLE ----
      do_arm();
      check("armed_clears_halted", a_halted, 1'b0);
      do_stop();
      check("armed_stop_done", a_state, 2'd3);
      check("armed_stop_count", a_count, 5'd0);
      check("armed_stop_rd_valid", a_rd_valid, 1'b0);
      tick();
      check("armed_stop_idle", a_state, 2'd0);

      // ---- 6: arm from DONE with 7 entries, then addi x5,x0,5 ----
      do_arm();
      for (int i = 0; i < 7; i++) retire(32'(32'h100 + i * 4), 32'h0000_0013, 1'b0, 5'd0, 32'd0);
      do_stop();
      check("t6_count7", a_count, 5'd7);
      check("t6_done", a_state, 2'd3);
      do_arm();
      check("t6_rearm_state", a_state, 2'd1);
      check("t6_rearm_count", a_count, 5'd0);
      check("t6_rearm_rd_valid", a_rd_valid, 1'b0);
      retire(32'h200, 32'h0050_0293, 1'b1, 5'd5, 32'd5);
      do_stop();
      check("t6_count1", a_count, 5'd1);
      e = unpack_entry(a_entry);
      check("t6_pc", e.pc, 32'h200);
      check("t6_instr", e.instr, 32'h0050_0293);
      check("t6_rd", e.rd, 5'd5);
      check("t6_rd_data", e.rd_data, 32'd5);
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      check("t6_idle", a_state, 2'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
